conv_job_scheduler: RTL and testbench

- Sequencer that walks a convolution engine across a full input feature map and produces one output feature map.
- Per output row, it commands the line buffer to load the three source rows for that row.
- It then issues one engine job for each pair of horizontally adjacent outputs. Each job yields two results.
- It sits between the host/config port and the convolution engine plus its line buffer, and owns all loop counters and destination addressing.

---
 rtl/conv_job_scheduler.sv | 144 ++++++++++++++
 tb/tb_conv_job_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_scheduler.sv
// Convolution job sequencer: walks output rows, loads line-buffer windows and issues two-result engine jobs.
// Optional CONV_SCHED_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module conv_job_scheduler #(
  parameter int DIM_W  = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_stride,
  input  logic [DIM_W-1:0]  cfg_img_w,
  input  logic [DIM_W-1:0]  cfg_img_h,
  input  logic [ADDR_W-1:0] cfg_dest_base,
  output logic              lb_load,
  output logic [DIM_W-1:0]  lb_row_base,
  input  logic              lb_load_done,
  output logic              eng_start,
  output logic [1:0]        eng_stride,
  output logic [ADDR_W-1:0] eng_dest_addr,
  output logic              eng_single,
  input  logic              eng_done,
  output logic              busy,
  output logic              frame_done,
  output logic              err_cfg
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [15:0]       perf_cycles
`endif
);

  // state | meaning
  // IDLE  | accepting config
  // LOAD  | line buffer loading the three source rows of output row oy
  // ISSUE | one-cycle engine job start for columns ox, ox+1
  // WAIT  | waiting for engine completion
  // DONE  | one-cycle end-of-frame pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]        stride_q;
  logic [DIM_W-1:0]  ow, oh, ox, oy;
  logic [ADDR_W-1:0] row_addr;
  logic [DIM_W-1:0]  w_m3, h_m3, ox_issue;
  logic              cfg_ok, accept, reject;
  logic              last_col, last_row, next_col, next_row, issue_load;

  assign cfg_ok   = (cfg_stride == 2'd1 || cfg_stride == 2'd2) &&
                    (cfg_img_w >= DIM_W'(3)) && (cfg_img_h >= DIM_W'(3));
  assign w_m3     = cfg_img_w - DIM_W'(3);
  assign h_m3     = cfg_img_h - DIM_W'(3);
  assign accept   = (state == S_IDLE) && cfg_valid && cfg_ok;
  assign reject   = (state == S_IDLE) && cfg_valid && !cfg_ok;

  // One extra bit so ox+2 cannot wrap past OW near the top of the range
  assign last_col = ({1'b0, ox} + (DIM_W+1)'(2)) >= {1'b0, ow};
  assign last_row = ({1'b0, oy} + (DIM_W+1)'(1)) >= {1'b0, oh};
  assign next_col = (state == S_WAIT) && eng_done && !last_col;
  assign next_row = (state == S_WAIT) && eng_done && last_col && !last_row;

  // Job outputs are registered on the edge into ISSUE, so use the column being moved to
  assign ox_issue   = next_col ? ox + DIM_W'(2) : ox;
  assign issue_load = next_col || ((state == S_LOAD) && lb_load_done);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD:  if (lb_load_done) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          if (!last_col)      state_nxt = S_ISSUE;
          else if (!last_row) state_nxt = S_LOAD;
          else                state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q      <= '0;
      ow            <= '0;
      oh            <= '0;
      ox            <= '0;
      oy            <= '0;
      row_addr      <= '0;
      lb_row_base   <= '0;
      lb_load       <= 1'b0;
      err_cfg       <= 1'b0;
      eng_stride    <= '0;
      eng_dest_addr <= '0;
      eng_single    <= 1'b0;
    end else begin
      err_cfg <= reject;
      lb_load <= accept || next_row;
      if (accept) begin
        stride_q    <= cfg_stride;
        ow          <= ((cfg_stride == 2'd2) ? (w_m3 >> 1) : w_m3) + DIM_W'(1);
        oh          <= ((cfg_stride == 2'd2) ? (h_m3 >> 1) : h_m3) + DIM_W'(1);
        ox          <= '0;
        oy          <= '0;
        row_addr    <= cfg_dest_base;
        lb_row_base <= '0;
      end
      if (next_col) ox <= ox + DIM_W'(2);
      // Row start address and window base advance incrementally; no multiplier needed
      if (next_row) begin
        ox          <= '0;
        oy          <= oy + DIM_W'(1);
        row_addr    <= row_addr + ADDR_W'(ow);
        lb_row_base <= lb_row_base + DIM_W'(stride_q);
      end
      if (issue_load) begin
        eng_stride    <= stride_q;
        eng_dest_addr <= row_addr + ADDR_W'(ox_issue);
        eng_single    <= (ox_issue == ow - DIM_W'(1));
      end
    end
  end

  assign cfg_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign eng_start  = (state == S_ISSUE);
  assign frame_done = (state == S_DONE);

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          perf_cycles <= '0;
    else if (accept)                                  perf_cycles <= '0;
    else if (state != S_IDLE && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Scoreboard bench for conv_job_scheduler: expected row loads and jobs are queued at config time
// and popped as the DUT emits lb_load / eng_start.
module tb_conv_job_scheduler;
  localparam int DIM_W  = 4;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_stride = '0;
  logic [DIM_W-1:0]  cfg_img_w = '0;
  logic [DIM_W-1:0]  cfg_img_h = '0;
  logic [ADDR_W-1:0] cfg_dest_base = '0;
  logic              lb_load;
  logic [DIM_W-1:0]  lb_row_base;
  logic              lb_load_done = 1'b0;
  logic              eng_start;
  logic [1:0]        eng_stride;
  logic [ADDR_W-1:0] eng_dest_addr;
  logic              eng_single;
  logic              eng_done = 1'b0;
  logic              busy;
  logic              frame_done;
  logic              err_cfg;
`ifdef CONV_SCHED_PERF_EN
  logic [15:0]       perf_cycles;
`endif

  conv_job_scheduler #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_stride(cfg_stride),
    .cfg_img_w(cfg_img_w), .cfg_img_h(cfg_img_h), .cfg_dest_base(cfg_dest_base),
    .lb_load(lb_load), .lb_row_base(lb_row_base), .lb_load_done(lb_load_done),
    .eng_start(eng_start), .eng_stride(eng_stride), .eng_dest_addr(eng_dest_addr),
    .eng_single(eng_single), .eng_done(eng_done),
    .busy(busy), .frame_done(frame_done), .err_cfg(err_cfg)
`ifdef CONV_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int lb_q[$];
  int job_q[$];
  int frames_seen = 0;
  int frames_exp = 0;
  int n_eng = 0;
  int lb_dly = 1;
  int eng_dly = 1;
  int lb_cnt = 0;
  int eng_cnt = 0;
  logic eng_spur = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: job word = dest<<3 | single<<2 | stride
  task automatic push_frame(input int w, input int h, input int s, input int base);
    int ow, oh, sg;
    ow = (w - 3) / s + 1;
    oh = (h - 3) / s + 1;
    for (int oy = 0; oy < oh; oy++) begin
      lb_q.push_back(oy * s);
      for (int ox = 0; ox < ow; ox += 2) begin
        sg = (ox == ow - 1) ? 4 : 0;
        job_q.push_back((((base + oy * ow + ox) % 32) << 3) | sg | s);
      end
    end
    frames_exp++;
  endtask

  task automatic send_cfg(input int w, input int h, input int s, input int base);
    @(negedge clk);
    cfg_img_w = w[DIM_W-1:0];
    cfg_img_h = h[DIM_W-1:0];
    cfg_stride = s[1:0];
    cfg_dest_base = base[ADDR_W-1:0];
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int k;
    k = 0;
    while (frames_seen < frames_exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("frame_timeout", frames_seen, frames_exp);
    check_val("lb_q_left", lb_q.size(), 0);
    check_val("job_q_left", job_q.size(), 0);
    @(negedge clk);
    check_val("idle_busy", busy, 0);
    check_val("idle_cfg_ready", cfg_ready, 1);
  endtask

  task automatic run_frame(input int w, input int h, input int s, input int base);
    push_frame(w, h, s, base);
    send_cfg(w, h, s, base);
    wait_frame(2000);
  endtask

  // Line buffer and engine responders
  initial begin
    logic eng_resp;
    forever begin
      @(negedge clk);
      eng_resp = 1'b0;
      if (rst) begin
        lb_cnt = 0;
        eng_cnt = 0;
        lb_load_done = 1'b0;
      end else begin
        lb_load_done = 1'b0;
        if (lb_cnt > 0) begin
          lb_cnt--;
          if (lb_cnt == 0) lb_load_done = 1'b1;
        end
        if (lb_load) begin
          if (lb_dly == 0) lb_load_done = 1'b1;
          else lb_cnt = lb_dly;
        end
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) eng_resp = 1'b1;
        end
        if (eng_start) eng_cnt = eng_dly;
      end
      eng_done = eng_resp | eng_spur;
    end
  end

  // Output monitor
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (lb_load) begin
          if (lb_q.size() == 0) check_val("lb_unexpected", lb_load, 0);
          else begin
            e = lb_q.pop_front();
            check_val("lb_row_base", lb_row_base, e);
          end
        end
        if (eng_start) begin
          n_eng++;
          if (job_q.size() == 0) check_val("eng_unexpected", eng_start, 0);
          else begin
            e = job_q.pop_front();
            check_val("eng_dest_addr", eng_dest_addr, e >> 3);
            check_val("eng_single", eng_single, (e >> 2) & 1);
            check_val("eng_stride", eng_stride, e & 3);
          end
        end
        if (frame_done) frames_seen++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int bad_w[4] = '{8, 2, 8, 8};
    int bad_h[4] = '{8, 8, 2, 8};
    int bad_s[4] = '{3, 1, 1, 0};
    int k, start_eng, start_frames;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_cfg_ready", cfg_ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_lb_load", lb_load, 0);
    check_val("rst_eng_start", eng_start, 0);
    check_val("rst_frame_done", frame_done, 0);
    check_val("rst_err_cfg", err_cfg, 0);

    run_frame(8, 8, 1, 0);
    run_frame(7, 7, 2, 4);

    for (int i = 0; i < 4; i++) begin
      send_cfg(bad_w[i], bad_h[i], bad_s[i], 0);
      check_val("err_cfg_pulse", err_cfg, 1);
      check_val("err_busy", busy, 0);
      check_val("err_cfg_ready", cfg_ready, 1);
      @(negedge clk);
      check_val("err_cfg_clear", err_cfg, 0);
      check_val("err_busy_after", busy, 0);
    end

    // Spurious eng_done during LOAD plus a competing config while busy
    lb_dly = 5;
    push_frame(5, 4, 1, 10);
    send_cfg(5, 4, 1, 10);
    @(posedge clk); #1;
    eng_spur = 1'b1;
    cfg_stride = 2'd2;
    cfg_img_w = 4'd15;
    cfg_img_h = 4'd15;
    cfg_dest_base = 5'd0;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    eng_spur = 1'b0;
    cfg_valid = 1'b0;
    check_val("busy_cfg_ready", cfg_ready, 0);
    check_val("busy_in_load", busy, 1);
    wait_frame(2000);
    lb_dly = 1;

    // Same-cycle load completion and address wrap
    lb_dly = 0;
    eng_dly = 3;
    run_frame(6, 3, 1, 30);
    lb_dly = 1;
    eng_dly = 1;

    run_frame(3, 5, 2, 31);

    // Reset during WAIT of the second job
    eng_dly = 4;
    push_frame(8, 3, 1, 0);
    start_eng = n_eng;
    send_cfg(8, 3, 1, 0);
    k = 0;
    while (n_eng < start_eng + 2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_val("job2_timeout", n_eng, start_eng + 2);
    @(posedge clk); #1;
    check_val("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_val("arst_busy", busy, 0);
    check_val("arst_cfg_ready", cfg_ready, 1);
    check_val("arst_eng_start", eng_start, 0);
    check_val("arst_lb_load", lb_load, 0);
    check_val("arst_dest", eng_dest_addr, 0);
    check_val("arst_single", eng_single, 0);
    check_val("arst_stride", eng_stride, 0);
    check_val("arst_row_base", lb_row_base, 0);
    lb_q.delete();
    job_q.delete();
    frames_exp--;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    eng_dly = 1;
    start_eng = n_eng;
    start_frames = frames_seen;
    repeat (20) @(negedge clk);
    check_val("post_rst_eng", n_eng, start_eng);
    check_val("post_rst_frames", frames_seen, start_frames);
    check_val("post_rst_busy", busy, 0);

    run_frame(7, 7, 2, 4);

`ifdef CONV_SCHED_PERF_EN
    run_frame(3, 3, 1, 0);
    check_val("perf_cycles", perf_cycles, 5);
    repeat (5) @(negedge clk);
    check_val("perf_hold", perf_cycles, 5);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
